// File: rtl/dual_rail_rx.sv
// dual_rail_rx: dual-rail return-to-zero receiver with completion detection,
// 4-phase ack to the sender and a single-rail valid/ready output port.
module dual_rail_rx #(
  parameter int WIDTH       = 8,
  parameter int SYNC_STAGES = 2,
  parameter int TMO_CYC     = 255
) (
  input  logic             CK,
  input  logic             RN,
  input  logic [WIDTH-1:0] rail_t,
  input  logic [WIDTH-1:0] rail_f,
  output logic             ack,
  output logic [WIDTH-1:0] out_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             err,
  output logic             tmo
);
  typedef enum logic [2:0] {NULL_WAIT, DATA_WAIT, CAPTURE, ACK_HI, ERR_NULL} state_t;
  state_t state_q, state_d;
  logic [SYNC_STAGES-1:0][WIDTH-1:0] st_q, st_d, sf_q, sf_d;
  logic [SYNC_STAGES-1:0] prime_q, prime_d;
  logic [WIDTH-1:0] prev_t_q, prev_t_d, out_data_q, out_data_d;
  logic [15:0] cnt_q, cnt_d;
  logic stab_q, stab_d, ill_q, ill_d, ack_q, ack_d;
  logic out_valid_q, out_valid_d, err_q, err_d, tmo_q, tmo_d;
  logic [WIDTH-1:0] s_t, s_f;
  logic all_null, complete, illegal, stable, load;
  assign s_t      = st_q[SYNC_STAGES-1];
  assign s_f      = sf_q[SYNC_STAGES-1];
  assign all_null = ~|(s_t | s_f);
  assign complete = &(s_t ^ s_f);
  assign illegal  = |(s_t & s_f);
  assign stable   = complete && stab_q && (s_t == prev_t_q);
  // prime_q marks when the synchronisers hold real rail samples after reset,
  // so reset-cleared flops are not mistaken for an all-null codeword
  always_comb begin
    st_d        = {st_q[SYNC_STAGES-2:0], rail_t};
    sf_d        = {sf_q[SYNC_STAGES-2:0], rail_f};
    prime_d     = {prime_q[SYNC_STAGES-2:0], 1'b1};
    prev_t_d    = s_t;
    stab_d      = (state_q == DATA_WAIT) && complete;
    ill_d       = illegal;
    state_d     = state_q;
    cnt_d       = cnt_q;
    ack_d       = ack_q;
    err_d       = 1'b0;
    tmo_d       = 1'b0;
    case (state_q)
      NULL_WAIT: state_d = (prime_q[SYNC_STAGES-1] && all_null) ? DATA_WAIT : NULL_WAIT;
      DATA_WAIT: begin
        if (illegal) begin
          err_d   = 1'b1;
          cnt_d   = '0;
          state_d = ERR_NULL;
        end else if (stable) begin
          state_d = CAPTURE;
        end else if (all_null) begin
          cnt_d = '0;
        end else if (!complete) begin
          tmo_d   = (cnt_q == 16'(TMO_CYC - 1));
          cnt_d   = tmo_d ? '0 : cnt_q + 16'd1;
          state_d = tmo_d ? ERR_NULL : DATA_WAIT;
        end
      end
      ACK_HI: begin
        ack_d   = all_null ? 1'b0 : ack_q;
        state_d = all_null ? DATA_WAIT : ACK_HI;
        err_d   = !all_null && illegal && !ill_q;
      end
      ERR_NULL: state_d = all_null ? DATA_WAIT : ERR_NULL;
      CAPTURE:  state_d = CAPTURE;
      default:  state_d = NULL_WAIT;
    endcase
    // a stable word loads on the same edge it is recognised unless back-pressured
    load = (state_d == CAPTURE) && (!out_valid_q || out_ready);
    if (load) begin
      state_d = ACK_HI;
      ack_d   = 1'b1;
      cnt_d   = '0;
    end
    out_valid_d = load || (out_valid_q && !out_ready);
    out_data_d  = load ? s_t : out_data_q;
  end
  always_ff @(posedge CK or negedge RN)
    if (!RN) begin
      state_q     <= NULL_WAIT;
      st_q        <= '0;
      sf_q        <= '0;
      prime_q     <= '0;
      prev_t_q    <= '0;
      stab_q      <= 1'b0;
      ill_q       <= 1'b0;
      cnt_q       <= '0;
      ack_q       <= 1'b0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      err_q       <= 1'b0;
      tmo_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      st_q        <= st_d;
      sf_q        <= sf_d;
      prime_q     <= prime_d;
      prev_t_q    <= prev_t_d;
      stab_q      <= stab_d;
      ill_q       <= ill_d;
      cnt_q       <= cnt_d;
      ack_q       <= ack_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      err_q       <= err_d;
      tmo_q       <= tmo_d;
    end
  assign ack       = ack_q;
  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign err       = err_q;
  assign tmo       = tmo_q;
endmodule

// File: tb/tb_dual_rail_rx.sv
// tb_dual_rail_rx: 4-phase sender model plus a scoreboard of expected words
// and error/timeout pulses, checked by an independent output monitor.
module tb_dual_rail_rx;
  logic CK = 1'b0, RN = 1'b0, out_ready = 1'b0;
  logic [7:0] rail_t = '0, rail_f = '0;
  logic ack, out_valid, err, tmo;
  logic [7:0] out_data;
  int vectors = 0, miscompares = 0;
  int exp_err = 0, exp_tmo = 0, err_seen = 0, tmo_seen = 0;
  int rdy_mode = 1;
  logic [7:0] sb[$];
  logic hold_v = 1'b0;
  logic [7:0] hold_d = '0;

  dual_rail_rx #(.WIDTH(8), .SYNC_STAGES(2), .TMO_CYC(10)) dut (
    .CK(CK), .RN(RN), .rail_t(rail_t), .rail_f(rail_f), .ack(ack),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .err(err), .tmo(tmo)
  );

  always #5 CK = ~CK;

  always @(posedge CK) begin
    #2;
    out_ready = (rdy_mode == 2) ? ($urandom_range(0, 3) != 0) : (rdy_mode == 1);
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h, expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  always @(negedge CK) begin
    if (!RN) begin
      hold_v = 1'b0;
    end else begin
      if (hold_v) chk("data_stable", out_data, hold_d);
      if (out_valid && out_ready) begin
        if (sb.size() == 0) begin
          vectors++;
          miscompares++;
          $display("FAIL spurious_word: got %0h, expected no word", out_data);
        end else chk("word", out_data, sb.pop_front());
      end
      if (err && tmo) begin
        vectors++;
        miscompares++;
        $display("FAIL err_tmo_exclusive: got both high, expected at most one");
      end
      err_seen += int'(err);
      tmo_seen += int'(tmo);
      hold_v = out_valid && !out_ready;
      hold_d = out_data;
    end
  end

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge CK);
      #1;
    end
  endtask

  task automatic drive(input logic [7:0] w, input logic [7:0] m = 8'hFF);
    rail_t = w & m;
    rail_f = ~w & m;
  endtask

  task automatic wait_ack(input logic v);
    int n = 0;
    while (ack !== v && n < 300) begin
      tick();
      n++;
    end
    chk("ack_wait", ack, v);
  endtask

  task automatic send(input logic [7:0] w, input bit skew);
    logic [7:0] m = '0;
    int s = $urandom_range(0, 7);
    sb.push_back(w);
    if (skew)
      for (int i = 0; i < 7; i++) begin
        m[(s + i) % 8] = 1'b1;
        drive(w, m);
        tick();
      end
    drive(w);
    wait_ack(1'b1);
    drive(8'h00, 8'h00);
    wait_ack(1'b0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] w;
    #3;
    chk("rst_ack", ack, 0);
    chk("rst_valid", out_valid, 0);
    chk("rst_data", out_data, 0);
    chk("rst_err_tmo", {err, tmo}, 0);
    tick(2);
    RN = 1'b1;
    tick(5);
    // 1: basic latency
    sb.push_back(8'hA5);
    drive(8'hA5);
    tick(3);
    chk("lat_valid_early", out_valid, 0);
    tick();
    chk("lat_valid", out_valid, 1);
    chk("lat_data", out_data, 8'hA5);
    chk("lat_ack", ack, 1);
    drive(8'h00, 8'h00);
    tick(2);
    chk("ack_fall_early", ack, 1);
    tick();
    chk("ack_fall", ack, 0);
    tick(3);
    // 2: back-pressure with simultaneous accept and load
    rdy_mode = 0;
    tick(2);
    send(8'h3C, 1'b0);
    sb.push_back(8'h81);
    drive(8'h81);
    tick(12);
    chk("bp_ack_held", ack, 0);
    chk("bp_valid", out_valid, 1);
    chk("bp_data", out_data, 8'h3C);
    rdy_mode = 1;
    tick(2);
    chk("bp_ack_after", ack, 1);
    chk("bp_data_next", out_data, 8'h81);
    drive(8'h00, 8'h00);
    wait_ack(1'b0);
    tick(3);
    // 3: skewed arrival
    sb.push_back(8'h96);
    drive(8'h96, 8'h0F);
    tick(3);
    drive(8'h96);
    wait_ack(1'b1);
    drive(8'h00, 8'h00);
    wait_ack(1'b0);
    tick(3);
    chk("skew_no_err", err_seen, exp_err);
    chk("skew_no_tmo", tmo_seen, exp_tmo);
    // 4: illegal code
    rail_t = 8'h04;
    rail_f = 8'h04;
    exp_err++;
    tick(2);
    chk("err_early", err, 0);
    tick();
    chk("err_pulse", err, 1);
    tick();
    chk("err_one_cycle", err, 0);
    tick(6);
    chk("err_no_ack", ack, 0);
    chk("err_no_capture", out_valid, 0);
    drive(8'h00, 8'h00);
    tick(4);
    send(8'h11, 1'b0);
    chk("err_count", err_seen, exp_err);
    tick(3);
    // 5: timeout on partial word
    drive(8'h5A, 8'h7F);
    exp_tmo++;
    tick(11);
    chk("tmo_early", tmo, 0);
    tick();
    chk("tmo_pulse", tmo, 1);
    tick();
    chk("tmo_one_cycle", tmo, 0);
    tick(4);
    drive(8'h00, 8'h00);
    tick(4);
    send(8'hC3, 1'b0);
    chk("tmo_count", tmo_seen, exp_tmo);
    tick(3);
    // 6: reset mid-handshake
    sb.push_back(8'h5E);
    drive(8'h5E);
    wait_ack(1'b1);
    tick();
    RN = 1'b0;
    #1;
    chk("rn_ack", ack, 0);
    chk("rn_valid", out_valid, 0);
    tick(2);
    RN = 1'b1;
    tick(10);
    chk("rn_hold_ack", ack, 0);
    chk("rn_hold_valid", out_valid, 0);
    drive(8'h00, 8'h00);
    tick(5);
    send(8'h77, 1'b0);
    tick(3);
    // randomized traffic
    rdy_mode = 2;
    for (int k = 0; k < 40; k++) begin
      w = 8'($urandom);
      if ($urandom_range(0, 7) == 0) begin
        rail_t = w | 8'(1 << $urandom_range(0, 7));
        rail_f = ~w | rail_t;
        exp_err++;
        tick(6);
        drive(8'h00, 8'h00);
        tick(4);
      end else send(w, $urandom_range(0, 1) == 1);
      tick($urandom_range(0, 3));
    end
    rdy_mode = 1;
    tick(10);
    chk("queue_drained", sb.size(), 0);
    chk("final_err_count", err_seen, exp_err);
    chk("final_tmo_count", tmo_seen, exp_tmo);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
